// File: rtl/fm_pkg.sv
// Shared feature-map buffer parameters and sequencer state encoding, common to
// the write controller, the read sequencer and the read-port mux.
package fm_pkg;

    localparam int NUM_KERNELS = 8;
    localparam int FM_DEPTH    = 64;
    localparam int ADDR_W      = 6;
    localparam int SEL_W       = 3;
    localparam int IDX_W       = 9;
    localparam int RD_LATENCY  = 2;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } fm_state_e;

    // Counter width for values 0..x-1, never narrower than one bit.
    function automatic int fm_clog2(input int x);
        return (x <= 2) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/fm_tag_delay.sv
// Fixed-depth delay line that carries the per-issue {valid,first,last,index} tag
// so it lines up with data leaving the RAM + read-port mux.
module fm_tag_delay #(
    parameter int W     = 12,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [DEPTH-1:0][W-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fm_read_sequencer.sv
// Read-side sweep of all feature-map buffers: drives shared address / mux select
// and emits a tagged pixel stream aligned with the mux output.
module fm_read_sequencer #(
    parameter int NUM_KERNELS = fm_pkg::NUM_KERNELS,
    parameter int FM_DEPTH    = fm_pkg::FM_DEPTH,
    parameter int ADDR_W      = fm_pkg::ADDR_W,
    parameter int SEL_W       = fm_pkg::SEL_W,
    parameter int IDX_W       = fm_pkg::IDX_W,
    parameter int RD_LATENCY  = fm_pkg::RD_LATENCY
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] addr,
    output logic [SEL_W-1:0]  ram_select,
    output logic              feature_valid,
    output logic              feature_first,
    output logic              feature_last,
    output logic [IDX_W-1:0]  weight_index,
    output logic              busy,
    output logic              buffer_release,
    output logic              product_rdy
);

    import fm_pkg::*;

    localparam int DCNT_W = fm_clog2(RD_LATENCY);
    localparam int TAG_W  = IDX_W + 3;

    fm_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DCNT_W-1:0]  drain_q, drain_d;
    logic               release_q, release_d;

    logic               issue;
    logic               last_issue;
    logic [TAG_W-1:0]   tag_in, tag_out;

    assign issue      = (state_q == READ);
    assign last_issue = issue && (addr_q == ADDR_W'(FM_DEPTH - 1))
                              && (sel_q == SEL_W'(NUM_KERNELS - 1));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        drain_d   = drain_q;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                addr_d = '0;
                sel_d  = '0;
                idx_d  = '0;
                if (start) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (last_issue) begin
                    // Hold the terminal address; every read has now been issued.
                    state_d   = DRAIN;
                    drain_d   = DCNT_W'(RD_LATENCY - 1);
                    release_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    if (addr_q == ADDR_W'(FM_DEPTH - 1)) begin
                        addr_d = '0;
                        sel_d  = sel_q + SEL_W'(1);
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - DCNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                addr_d  = '0;
                sel_d   = '0;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            sel_q     <= '0;
            idx_q     <= '0;
            drain_q   <= '0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            drain_q   <= drain_d;
            release_q <= release_d;
        end
    end

    // Index is zeroed outside READ so the delayed tag is all-zero when not valid.
    assign tag_in = {issue, issue && (idx_q == '0), last_issue, issue ? idx_q : '0};

    fm_tag_delay #(
        .W     (TAG_W),
        .DEPTH (RD_LATENCY)
    ) u_tag_delay (
        .clock (clock),
        .reset (reset),
        .din   (tag_in),
        .dout  (tag_out)
    );

    assign addr           = addr_q;
    assign ram_select     = sel_q;
    assign feature_valid  = tag_out[IDX_W+2];
    assign feature_first  = tag_out[IDX_W+1];
    assign feature_last   = tag_out[IDX_W];
    assign weight_index   = tag_out[IDX_W-1:0];
    assign busy           = (state_q != IDLE);
    assign buffer_release = release_q;
    assign product_rdy    = (state_q == DONE);

endmodule

// File: tb/tb_fm_read_sequencer.sv
// Scoreboard bench: sweep schedule predicted from start/reset timing, pixel data
// from a behavioural RAM + registered mux read path.
module tb_fm_read_sequencer;

    localparam int K  = 2;
    localparam int D  = 4;
    localparam int L  = 2;
    localparam int N  = K * D;
    localparam int AW = 2;
    localparam int SW = 1;
    localparam int IW = 3;

    typedef struct {
        int         cyc;
        int         idx;
        bit         first;
        bit         last;
        logic [7:0] data;
    } pix_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] addr;
    logic [SW-1:0] ram_select;
    logic          feature_valid, feature_first, feature_last;
    logic [IW-1:0] weight_index;
    logic          busy, buffer_release, product_rdy;

    fm_read_sequencer #(
        .NUM_KERNELS (K),
        .FM_DEPTH    (D),
        .ADDR_W      (AW),
        .SEL_W       (SW),
        .IDX_W       (IW),
        .RD_LATENCY  (L)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .addr           (addr),
        .ram_select     (ram_select),
        .feature_valid  (feature_valid),
        .feature_first  (feature_first),
        .feature_last   (feature_last),
        .weight_index   (weight_index),
        .busy           (busy),
        .buffer_release (buffer_release),
        .product_rdy    (product_rdy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural feature-map RAMs: registered RAM read, then registered mux.
    logic [7:0] ram [K][D];
    logic [7:0] rd1, rd2;
    always @(posedge clock) begin
        rd1 <= ram[ram_select][addr];
        rd2 <= rd1;
    end

    // Reference model state: active busy window [lo,hi], first cycle start is accepted.
    int   lo = 0, hi = -1, free = 0;
    pix_t pq[$];
    int   rq[$];
    int   dq[$];
    bit   rnd_ram = 1'b0;
    int   checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    // Drive inputs for the current cycle, advance the model, then move to the next cycle.
    task automatic apply(input bit r, input bit s);
        pix_t p;
        reset = r;
        start = s;
        if (r) begin
            if (hi > cyc) hi = cyc;
            while (pq.size() > 0 && pq[$].cyc > cyc) void'(pq.pop_back());
            while (rq.size() > 0 && rq[$] > cyc) void'(rq.pop_back());
            while (dq.size() > 0 && dq[$] > cyc) void'(dq.pop_back());
            free = cyc + 1;
        end else if (cyc >= free) begin
            if (rnd_ram && $urandom_range(0, 2) == 0) begin
                for (int k = 0; k < K; k++)
                    for (int a = 0; a < D; a++) ram[k][a] = 8'($urandom);
            end
            if (s) begin
                lo   = cyc + 1;
                hi   = cyc + N + L + 1;
                free = cyc + N + L + 2;
                for (int k = 0; k < N; k++) begin
                    p.cyc   = cyc + 1 + k + L;
                    p.idx   = k;
                    p.first = (k == 0);
                    p.last  = (k == N - 1);
                    p.data  = ram[k / D][k % D];
                    pq.push_back(p);
                end
                rq.push_back(cyc + N + 1);
                dq.push_back(cyc + N + L + 1);
            end
        end
        @(posedge clock);
        #1;
    endtask

    // Monitor: compares every output each cycle against the model's expectations.
    always @(negedge clock) begin
        bit   eb, ev, er, ed;
        int   k;
        pix_t e;
        if (cyc >= 1) begin
            eb = (cyc >= lo && cyc <= hi);
            k  = 0;
            if (eb) begin
                k = cyc - lo;
                if (k > N - 1) k = N - 1;
            end
            chk("busy", 32'(busy), 32'(eb));
            chk("addr", 32'(addr), eb ? 32'(k % D) : 32'd0);
            chk("ram_select", 32'(ram_select), eb ? 32'(k / D) : 32'd0);
            ev = (pq.size() > 0 && pq[0].cyc == cyc);
            chk("feature_valid", 32'(feature_valid), 32'(ev));
            if (ev) begin
                e = pq.pop_front();
                chk("feature_first", 32'(feature_first), 32'(e.first));
                chk("feature_last", 32'(feature_last), 32'(e.last));
                chk("weight_index", 32'(weight_index), 32'(e.idx));
                chk("pixel_data", 32'(rd2), 32'(e.data));
            end else begin
                chk("idle_first", 32'(feature_first), 32'd0);
                chk("idle_last", 32'(feature_last), 32'd0);
                chk("idle_index", 32'(weight_index), 32'd0);
            end
            er = (rq.size() > 0 && rq[0] == cyc);
            if (er) void'(rq.pop_front());
            chk("buffer_release", 32'(buffer_release), 32'(er));
            ed = (dq.size() > 0 && dq[0] == cyc);
            if (ed) void'(dq.pop_front());
            chk("product_rdy", 32'(product_rdy), 32'(ed));
        end
    end

    initial begin
        for (int k = 0; k < K; k++)
            for (int a = 0; a < D; a++) ram[k][a] = 8'(16 * k + a);

        repeat (3) apply(1'b1, 1'b0);

        // Single sweep with re-pulses of start that must be ignored.
        for (int i = 0; i < 14; i++) apply(1'b0, i == 0 || i == 4 || i == 10);
        repeat (3) apply(1'b0, 1'b0);

        // start held high: back-to-back sweeps.
        repeat (30) apply(1'b0, 1'b1);
        repeat (15) apply(1'b0, 1'b0);

        // Reset mid-sweep, then restart.
        apply(1'b0, 1'b1);
        repeat (4) apply(1'b0, 1'b0);
        apply(1'b1, 1'b0);
        apply(1'b0, 1'b1);
        repeat (14) apply(1'b0, 1'b0);

        // Randomised traffic with fresh RAM contents between sweeps.
        rnd_ram = 1'b1;
        for (int i = 0; i < 600; i++)
            apply($urandom_range(0, 79) == 0, $urandom_range(0, 4) == 0);
        repeat (20) apply(1'b0, 1'b0);

        chk("pixels_outstanding", 32'(pq.size()), 32'd0);
        chk("release_outstanding", 32'(rq.size()), 32'd0);
        chk("product_outstanding", 32'(dq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
